hazard_scoreboard: RTL

Parametrised successor to the 5-stage pipeline hazard unit. It keeps E-stage forwarding and the load-use stall, and adds three things:
- a register scoreboard for one variable-latency multiply/divide (MD) unit
- taken-branch flush
- a saturating stall-cycle performance counter

It sits beside the datapath and drives all stall, flush and forward-select signals for the F/D/E pipeline registers.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/md_tracker.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard: forward-select
// encodings and the register-address width derived from the register count.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_MD = 2'b11;

   function automatic int raw_width(input int nreg);
      return $clog2(nreg);
   endfunction

endpackage

// File: rtl/md_tracker.sv
// Tracks the single in-flight multiply/divide operation: writeback countdown,
// destination register and the per-register pending scoreboard.
module md_tracker
   import hazard_pkg::*;
#(
   parameter  int NREG     = 32,
   parameter  int MD_LAT   = 4,
   parameter  int ZERO_REG = 1,
   localparam int RAW      = raw_width(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            md_op_E,
   input  logic [RAW-1:0]  write_reg_E,
   output logic [NREG-1:0] pending,
   output logic            md_busy,
   output logic            md_wb_valid,
   output logic [RAW-1:0]  md_wb_reg
);

   localparam int CW = $clog2(MD_LAT);

   logic [CW-1:0]   countdown;
   logic [NREG-1:0] pending_nxt;
   logic            issue_marks;

   assign md_busy     = (countdown != '0);
   assign md_wb_valid = (countdown == CW'(1));
   assign issue_marks = md_op_E && !((ZERO_REG != 0) && (write_reg_E == '0));

   // Clear the written-back register first; a fresh issue never targets the same cycle.
   always_comb begin
      pending_nxt = pending;
      if (md_wb_valid)
         pending_nxt[md_wb_reg] = 1'b0;
      if (issue_marks)
         pending_nxt[write_reg_E] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         countdown <= '0;
         md_wb_reg <= '0;
         pending   <= '0;
      end else begin
         pending <= pending_nxt;
         if (md_op_E) begin
            countdown <= CW'(MD_LAT - 1);
            md_wb_reg <= write_reg_E;
         end else if (countdown != '0) begin
            countdown <= countdown - CW'(1);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage forwarding, load-use / scoreboard / MD structural
// stalls, taken-branch flush and a saturating stall-cycle counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NREG     = 32,
   parameter  int MD_LAT   = 4,
   parameter  int CNT_W    = 16,
   parameter  int ZERO_REG = 1,
   localparam int RAW      = raw_width(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RAW-1:0]   rs_D,
   input  logic [RAW-1:0]   rt_D,
   input  logic             uses_rs_D,
   input  logic             uses_rt_D,
   input  logic [RAW-1:0]   write_reg_D,
   input  logic             reg_write_D,
   input  logic             md_op_D,
   input  logic [RAW-1:0]   rs_E,
   input  logic [RAW-1:0]   rt_E,
   input  logic [RAW-1:0]   write_reg_E,
   input  logic             mem_to_reg_E,
   input  logic             md_op_E,
   input  logic             branch_taken_E,
   input  logic [RAW-1:0]   write_reg_M,
   input  logic             reg_write_M,
   input  logic [RAW-1:0]   write_reg_W,
   input  logic             reg_write_W,
   output logic [1:0]       forward_a_E,
   output logic [1:0]       forward_b_E,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic             flush_E,
   output logic             md_wb_valid,
   output logic [RAW-1:0]   md_wb_reg,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   logic [NREG-1:0] pending;
   logic            lw_stall;
   logic            raw_stall;
   logic            waw_stall;
   logic            md_stall;
   logic            any_stall;

   // Register 0 never matches when it is hard-wired.
   function automatic logic reg_match(input logic [RAW-1:0] a, input logic [RAW-1:0] b);
      return (a == b) && ((ZERO_REG == 0) || (a != '0));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src);
      if (reg_write_M && reg_match(src, write_reg_M))
         return FWD_M;
      else if (reg_write_W && reg_match(src, write_reg_W))
         return FWD_W;
      else if (md_wb_valid && reg_match(src, md_wb_reg))
         return FWD_MD;
      else
         return FWD_RF;
   endfunction

   md_tracker #(
      .NREG     (NREG),
      .MD_LAT   (MD_LAT),
      .ZERO_REG (ZERO_REG)
   ) u_md_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .md_op_E     (md_op_E),
      .write_reg_E (write_reg_E),
      .pending     (pending),
      .md_busy     (md_busy),
      .md_wb_valid (md_wb_valid),
      .md_wb_reg   (md_wb_reg)
   );

   assign forward_a_E = fwd_sel(rs_E);
   assign forward_b_E = fwd_sel(rt_E);

   // A pending source may proceed in the writeback cycle thanks to the write-through register file.
   always_comb begin
      lw_stall  = mem_to_reg_E &&
                  ((uses_rs_D && reg_match(rs_D, write_reg_E)) ||
                   (uses_rt_D && reg_match(rt_D, write_reg_E)));
      raw_stall = (uses_rs_D && pending[rs_D] && !(md_wb_valid && reg_match(rs_D, md_wb_reg))) ||
                  (uses_rt_D && pending[rt_D] && !(md_wb_valid && reg_match(rt_D, md_wb_reg)));
      waw_stall = reg_write_D && pending[write_reg_D] && !md_wb_valid;
      md_stall  = md_op_D && (md_busy || md_op_E);
      any_stall = lw_stall || raw_stall || waw_stall || md_stall;
   end

   // A taken branch squashes the younger stages, overriding any stall.
   always_comb begin
      if (branch_taken_E) begin
         stall_F = 1'b0;
         stall_D = 1'b0;
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else begin
         stall_F = any_stall;
         stall_D = any_stall;
         flush_D = 1'b0;
         flush_E = any_stall;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_count <= '0;
      else if (stall_D && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule
